// File: rtl/eth_evt_ctrl_if.sv
// rtl/eth_evt_ctrl_if.sv - register command/readback bus for eth_evt_ctrl
interface eth_evt_ctrl_if;
  logic [7:0]  i_cmd_addr;
  logic [31:0] i_cmd_data;
  logic        i_cmd_wr;
  logic [7:0]  i_rd_addr;
  logic [31:0] o_rd_data;

  modport master (
    output i_cmd_addr, i_cmd_data, i_cmd_wr, i_rd_addr,
    input  o_rd_data
  );

  modport slave (
    input  i_cmd_addr, i_cmd_data, i_cmd_wr, i_rd_addr,
    output o_rd_data
  );
endinterface

// File: rtl/eth_evt_ctrl.sv
// rtl/eth_evt_ctrl.sv - per-channel rx event counters with coalesced interrupt
module eth_evt_ctrl #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int TMO_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  i_evt,
  eth_evt_ctrl_if.slave    bus,
  output logic             o_irq,
  output logic [7:0]       o_green_led
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_GATHER = 2'd1, S_FIRE = 2'd2} state_t;

  state_t           r_state;
  logic             r_en;
  logic [N_CH-1:0]  r_mask;
  logic [CNT_W-1:0] r_thresh;
  logic [TMO_W-1:0] r_tmo;
  logic [CNT_W-1:0] r_pend;
  logic [TMO_W-1:0] r_timer;
  logic             r_irq;
  logic [31:0]      r_total;
  logic [31:0]      r_rd_data;
  logic [CNT_W-1:0] r_cnt [N_CH];

  logic [3:0]       w_evt_cnt;
  logic [3:0]       w_m;
  logic             w_ack;
  logic             w_dis;
  logic [CNT_W:0]   w_pend_sum;
  logic [CNT_W-1:0] w_pend_nxt;
  logic [CNT_W-1:0] w_thr;
  logic [TMO_W-1:0] w_timer_inc;
  logic             w_hit_thr;
  logic             w_hit_tmo;
  logic [31:0]      w_rd;
  logic             w_unused_data;

  always_comb begin
    w_evt_cnt = '0;
    w_m       = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_evt_cnt = w_evt_cnt + 4'(i_evt[k]);
      w_m       = w_m + 4'(i_evt[k] & r_mask[k] & r_en);
    end
  end

  // Clearing EN by a write takes the coalescing path down on the same edge.
  assign w_ack = bus.i_cmd_wr && (bus.i_cmd_addr == 8'h03);
  assign w_dis = !r_en || (bus.i_cmd_wr && (bus.i_cmd_addr == 8'h00) && !bus.i_cmd_data[0]);

  assign w_pend_sum  = {1'b0, r_pend} + (CNT_W+1)'(w_m);
  assign w_pend_nxt  = w_ack ? CNT_W'(w_m) :
                       (w_pend_sum[CNT_W] ? '1 : w_pend_sum[CNT_W-1:0]);
  assign w_thr       = (r_thresh == '0) ? CNT_W'(1) : r_thresh;
  assign w_hit_thr   = (w_pend_nxt >= w_thr);
  assign w_timer_inc = r_timer + TMO_W'(1);
  assign w_hit_tmo   = (r_tmo != '0) && (w_timer_inc == r_tmo);
  assign w_unused_data = ^bus.i_cmd_data;

  always_ff @(posedge clk) begin
    if (!rst_n || w_dis) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_timer <= '0;
      r_irq   <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_m != '0) begin
            if (w_hit_thr) begin
              r_state <= S_FIRE;
              r_irq   <= 1'b1;
            end else begin
              r_state <= S_GATHER;
              r_timer <= '0;
            end
          end
        end
        S_GATHER: begin
          if (w_ack) begin
            r_state <= (w_m != '0) ? S_GATHER : S_IDLE;
            r_timer <= '0;
          end else if (w_hit_thr || w_hit_tmo) begin
            r_state <= S_FIRE;
            r_irq   <= 1'b1;
          end else begin
            r_timer <= w_timer_inc;
          end
        end
        S_FIRE: begin
          if (w_ack) begin
            r_state <= (w_m != '0) ? S_GATHER : S_IDLE;
            r_timer <= '0;
            r_irq   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    case (bus.i_rd_addr)
      8'h00: begin
        w_rd[0]         = r_en;
        w_rd[8 +: N_CH] = r_mask;
      end
      8'h01: w_rd[CNT_W-1:0] = r_thresh;
      8'h02: w_rd[TMO_W-1:0] = r_tmo;
      8'h04: begin
        w_rd[CNT_W-1:0] = r_pend;
        w_rd[29:28]     = r_state;
      end
      8'h05: w_rd = r_total;
      default: begin
        for (int k = 0; k < N_CH; k++)
          if (bus.i_rd_addr == 8'(16 + k)) w_rd[CNT_W-1:0] = r_cnt[k];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en      <= 1'b0;
      r_mask    <= '0;
      r_thresh  <= CNT_W'(1);
      r_tmo     <= '0;
      r_total   <= '0;
      r_rd_data <= '0;
      for (int k = 0; k < N_CH; k++) r_cnt[k] <= '0;
    end else begin
      r_rd_data <= w_rd;
      r_total   <= r_total + 32'(w_evt_cnt);
      if (bus.i_cmd_wr) begin
        case (bus.i_cmd_addr)
          8'h00: begin
            r_en   <= bus.i_cmd_data[0];
            r_mask <= bus.i_cmd_data[8 +: N_CH];
          end
          8'h01: r_thresh <= bus.i_cmd_data[CNT_W-1:0];
          8'h02: r_tmo    <= bus.i_cmd_data[TMO_W-1:0];
          default: ;
        endcase
      end
      // A clear colliding with an event keeps that event: the count restarts at 1.
      for (int k = 0; k < N_CH; k++) begin
        if (bus.i_cmd_wr && (bus.i_cmd_addr == 8'(16 + k)))
          r_cnt[k] <= CNT_W'(i_evt[k]);
        else if (i_evt[k] && (r_cnt[k] != '1))
          r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  assign bus.o_rd_data = r_rd_data;
  assign o_irq         = r_irq;
  assign o_green_led   = r_total[7:0];

endmodule
